// File: rtl/banco_registradores.sv
// Register bank with per-entry valid flags, two combinational read ports,
// optional write-to-read forwarding and a registered count of valid entries.
module banco_registradores #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             escreve,
    input  logic [AW-1:0]    endereco_w,
    input  logic [WIDTH-1:0] d,
    input  logic             limpa,
    input  logic [AW-1:0]    endereco_a,
    input  logic [AW-1:0]    endereco_b,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qb,
    output logic             valido_a,
    output logic             valido_b,
    output logic [AW:0]      ocupados
);

    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW:0]      r_ocup;

    logic w_wr_legal;
    logic w_wr_fwd;

    assign w_wr_legal = ({1'b0, endereco_w} < LIM);
    // Forwarding only when the write will actually commit on the coming edge.
    assign w_wr_fwd   = escreve && w_wr_legal && rst && !limpa;

    always_ff @(posedge clk) begin
        if (!rst || limpa) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_vld  <= '0;
            r_ocup <= '0;
        end else if (escreve && w_wr_legal) begin
            r_mem[endereco_w] <= d;
            r_vld[endereco_w] <= 1'b1;
            if (!r_vld[endereco_w]) r_ocup <= r_ocup + (AW+1)'(1);
        end
    end

    // Returns {valid, data} for one read port.
    function automatic logic [WIDTH:0] rd_port(input logic [AW-1:0] a);
        logic [WIDTH:0] r;
        r = '0;
        if ({1'b0, a} < LIM) r = {r_vld[a], r_mem[a]};
        if (BYPASS != 0 && w_wr_fwd && a == endereco_w) r = {1'b1, d};
        return r;
    endfunction

    assign {valido_a, qa} = rd_port(endereco_a);
    assign {valido_b, qb} = rd_port(endereco_b);
    assign ocupados       = r_ocup;

endmodule
